// File: rtl/tmds_encoder_array.sv
// rtl/tmds_encoder_array.sv - multi-lane TMDS encoder with optional HDMI preamble/guard insertion
module tmds_encoder_array #(
    parameter int CHANNELS  = 3,
    parameter int SYNC_CH   = 0,
    parameter int HDMI_MODE = 0
) (
    input  logic                   clk_pix,
    input  logic                   rst_n,
    input  logic                   de,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic [2*CHANNELS-1:0]  ctl,
    input  logic [8*CHANNELS-1:0]  pix,
    output logic [10*CHANNELS-1:0] tmds,
    output logic                   video_o,
    output logic                   blank_err
);

    typedef enum logic [1:0] {P_CTRL, P_PREAMBLE, P_GUARD, P_VIDEO} period_t;

    localparam logic [9:0] SYM_C00      = 10'b1101010100;
    localparam logic [9:0] SYM_C01      = 10'b0010101011;
    localparam logic [9:0] SYM_C10      = 10'b0101010100;
    localparam logic [9:0] SYM_C11      = 10'b1010101011;
    localparam logic [9:0] SYM_GUARD_02 = 10'b1011001100;
    localparam logic [9:0] SYM_GUARD_1  = 10'b0100110011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int b = 0; b < 8; b++) n = n + {3'b000, v[b]};
        return n;
    endfunction

    function automatic logic [8:0] transition_min(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n;
        logic       inv;
        n    = ones8(d);
        inv  = (n > 4'd4) || (n == 4'd4 && !d[0]);
        q[0] = d[0];
        for (int b = 1; b < 8; b++) q[b] = q[b-1] ^ d[b] ^ inv;
        q[8] = ~inv;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return SYM_C00;
            2'b01:   return SYM_C01;
            2'b10:   return SYM_C10;
            default: return SYM_C11;
        endcase
    endfunction

    logic                  d_de, d_hs, d_vs;
    logic [2*CHANNELS-1:0] d_ctl;
    logic [8*CHANNELS-1:0] d_pix;
    logic [3:0]            lead_eff;
    logic                  err_set;
    period_t               period, period_r;

    generate
        if (HDMI_MODE != 0) begin : g_hdmi
            localparam int DW = 3 + 10*CHANNELS;
            logic [9:0][DW-1:0] line;
            logic [3:0]         lead;
            logic               rise;

            // The lead counter looks ahead of the delay line so the 10 slots
            // preceding each active period can be rewritten.
            always_ff @(posedge clk_pix or negedge rst_n) begin
                if (!rst_n) begin
                    line <= '0;
                    lead <= '0;
                end else begin
                    line <= {line[8:0], {de, hsync, vsync, ctl, pix}};
                    if (rise)
                        lead <= 4'd9;
                    else if (lead != 4'd0)
                        lead <= lead - 4'd1;
                end
            end

            assign {d_de, d_hs, d_vs, d_ctl, d_pix} = line[9];
            assign rise     = de & ~line[0][DW-1];
            assign lead_eff = rise ? 4'd10 : lead;
            assign err_set  = rise & ((lead != 4'd0) | line[9][DW-1]);
        end else begin : g_dvi
            assign {d_de, d_hs, d_vs, d_ctl, d_pix} = {de, hsync, vsync, ctl, pix};
            assign lead_eff = 4'd0;
            assign err_set  = 1'b0;
        end
    endgenerate

    always_comb begin
        period = P_CTRL;
        if (d_de)
            period = P_VIDEO;
        else if (lead_eff >= 4'd3)
            period = P_PREAMBLE;
        else if (lead_eff != 4'd0)
            period = P_GUARD;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            period_r  <= P_CTRL;
            video_o   <= 1'b0;
            blank_err <= 1'b0;
        end else begin
            period_r  <= period;
            video_o   <= (period_r == P_VIDEO);
            blank_err <= err_set;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic [1:0]        c_sel, c_r;
        logic [8:0]        qm, qm_r;
        logic [3:0]        n1_r;
        logic signed [4:0] cnt, cnt_nxt, bal;
        logic [9:0]        sym, vid_sym;

        assign qm = transition_min(d_pix[8*i +: 8]);

        // Preamble control codes are resolved here so stage 2 treats them as CTRL.
        always_comb begin
            c_sel = (i == SYNC_CH) ? {d_vs, d_hs} : d_ctl[2*i +: 2];
            if (period == P_PREAMBLE) begin
                if (i == 0)
                    c_sel = {d_vs, d_hs};
                else if (i == 1)
                    c_sel = 2'b01;
                else if (i == 2)
                    c_sel = 2'b00;
            end
        end

        always_ff @(posedge clk_pix or negedge rst_n) begin
            if (!rst_n) begin
                qm_r <= '0;
                n1_r <= '0;
                c_r  <= '0;
            end else begin
                qm_r <= qm;
                n1_r <= ones8(qm[7:0]);
                c_r  <= c_sel;
            end
        end

        // bal = N1 - N0 of q_m; 5-bit wrap is exact because results stay in [-10,+10].
        always_comb begin
            bal = $signed({n1_r, 1'b0}) - 5'sd8;
            if (cnt == 5'sd0 || bal == 5'sd0) begin
                vid_sym = {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]};
                cnt_nxt = qm_r[8] ? cnt + bal : cnt - bal;
            end else if ((cnt > 5'sd0 && bal > 5'sd0) || (cnt < 5'sd0 && bal < 5'sd0)) begin
                vid_sym = {1'b1, qm_r[8], ~qm_r[7:0]};
                cnt_nxt = cnt - bal + (qm_r[8] ? 5'sd2 : 5'sd0);
            end else begin
                vid_sym = {1'b0, qm_r[8], qm_r[7:0]};
                cnt_nxt = cnt + bal - (qm_r[8] ? 5'sd0 : 5'sd2);
            end
        end

        always_ff @(posedge clk_pix or negedge rst_n) begin
            if (!rst_n) begin
                sym <= SYM_C00;
                cnt <= '0;
            end else begin
                case (period_r)
                    P_VIDEO: begin
                        sym <= vid_sym;
                        cnt <= cnt_nxt;
                    end
                    P_GUARD: begin
                        sym <= (i == 1) ? SYM_GUARD_1 : SYM_GUARD_02;
                        cnt <= '0;
                    end
                    default: begin
                        sym <= ctrl_sym(c_r);
                        cnt <= '0;
                    end
                endcase
            end
        end

        assign tmds[10*i +: 10] = sym;
    end

endmodule

// File: tb/tb_tmds_encoder_array.sv
// tb/tb_tmds_encoder_array.sv - self-checking bench for tmds_encoder_array
module tb_tmds_encoder_array;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] G02 = 10'b1011001100;
    localparam logic [9:0] G1  = 10'b0100110011;
    localparam int RAND_N = 10000;
    localparam int TOT    = 125;
    localparam int HLEN   = TOT + 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic d_de, d_hs, d_vs, d_vid, d_err;
    logic [5:0]  d_ctl;
    logic [23:0] d_pix;
    logic [29:0] d_tmds;
    logic r_de, r_hs, r_vs, r_vid, r_err;
    logic [7:0]  r_ctl;
    logic [31:0] r_pix;
    logic [39:0] r_tmds;
    logic h_de, h_hs, h_vs, h_vid, h_err;
    logic [5:0]  h_ctl;
    logic [23:0] h_pix;
    logic [29:0] h_tmds;

    tmds_encoder_array #(.CHANNELS(3), .SYNC_CH(0), .HDMI_MODE(0)) u_dvi (
        .clk_pix(clk), .rst_n(rst_n), .de(d_de), .hsync(d_hs), .vsync(d_vs),
        .ctl(d_ctl), .pix(d_pix), .tmds(d_tmds), .video_o(d_vid), .blank_err(d_err));
    tmds_encoder_array #(.CHANNELS(4), .SYNC_CH(2), .HDMI_MODE(0)) u_rand (
        .clk_pix(clk), .rst_n(rst_n), .de(r_de), .hsync(r_hs), .vsync(r_vs),
        .ctl(r_ctl), .pix(r_pix), .tmds(r_tmds), .video_o(r_vid), .blank_err(r_err));
    tmds_encoder_array #(.CHANNELS(3), .SYNC_CH(0), .HDMI_MODE(1)) u_hdmi (
        .clk_pix(clk), .rst_n(rst_n), .de(h_de), .hsync(h_hs), .vsync(h_vs),
        .ctl(h_ctl), .pix(h_pix), .tmds(h_tmds), .video_o(h_vid), .blank_err(h_err));

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return C00;
            2'b01:   return C01;
            2'b10:   return C10;
            default: return C11;
        endcase
    endfunction

    // Reference encoder: q_m bits from prefix parity, disparity from output ones count.
    function automatic void ref_video(input logic [7:0] d, input int cin,
                                      output logic [9:0] sym, output int cout);
        int         n1, a;
        bit         xn;
        logic       p;
        logic [8:0] q;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        p  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            p    = p ^ d[k];
            q[k] = (xn && (k % 2 == 1)) ? ~p : p;
        end
        q[8] = !xn;
        a    = $countones(q[7:0]);
        if (cin == 0 || a == 4)
            sym = q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
        else if ((cin > 0 && a > 4) || (cin < 0 && a < 4))
            sym = {1'b1, q[8], ~q[7:0]};
        else
            sym = {1'b0, q[8], q[7:0]};
        cout = cin + 2 * $countones(sym) - 10;
    endfunction

    typedef struct {
        logic        de, hs, vs;
        logic [5:0]  ctl;
        logic [7:0]  pix;
        logic [29:0] exp;
    } vec_t;

    function automatic vec_t vv(input logic de, hs, vs, input logic [5:0] ctl,
                                input logic [7:0] pix, input logic [29:0] exp);
        vec_t v;
        v.de = de; v.hs = hs; v.vs = vs; v.ctl = ctl; v.pix = pix; v.exp = exp;
        return v;
    endfunction

    typedef struct {
        logic [39:0] sym;
        logic        vid;
    } exp_t;

    exp_t        rq[$];
    int          rc[4];
    int          ds[4];
    int          hc[3];
    logic        hde[HLEN];
    logic        hhs[HLEN];
    logic        hvs[HLEN];
    logic [5:0]  hctl[HLEN];
    logic [23:0] hpix[HLEN];

    function automatic logic de_at(input int t);
        return (t < 0) ? 1'b0 : hde[t];
    endfunction

    function automatic logic rise_at(input int t);
        return (t >= 0) && hde[t] && !de_at(t - 1);
    endfunction

    // 3 = video, 1 = preamble, 2 = guard, 0 = control
    function automatic int hclass(input int t);
        int best;
        if (hde[t]) return 3;
        best = -1;
        for (int r = t + 1; r <= t + 10; r++)
            if (rise_at(r)) best = r;
        if (best < 0) return 0;
        return (best - t >= 3) ? 1 : 2;
    endfunction

    function automatic logic err_at(input int r);
        logic near;
        near = de_at(r - 10);
        for (int k = r - 9; k < r; k++)
            if (rise_at(k)) near = 1'b1;
        return rise_at(r) && near;
    endfunction

    initial begin
        vec_t        tv[12];
        exp_t        e;
        logic [9:0]  s;
        logic [29:0] hexp;
        logic [1:0]  c;
        int          nc, cls, pulses, r2, idx, lvl;
        logic        ok;
        int          seg_len[7];

        tv[0]  = vv(1, 0, 0, 6'b000000, 8'h00, {3{10'b0100000000}});
        tv[1]  = vv(1, 0, 0, 6'b000000, 8'h00, {3{10'b1111111111}});
        tv[2]  = vv(0, 1, 0, 6'b111011, 8'h00, {C11, C10, C01});
        tv[3]  = vv(1, 0, 0, 6'b000000, 8'h00, {3{10'b0100000000}});
        tv[4]  = vv(1, 0, 0, 6'b000000, 8'hFF, {3{10'b0011111111}});
        tv[5]  = vv(1, 0, 0, 6'b000000, 8'h10, {3{10'b0111110000}});
        tv[6]  = vv(1, 0, 0, 6'b000000, 8'h55, {3{10'b0100110011}});
        tv[7]  = vv(1, 0, 0, 6'b000000, 8'hAA, {3{10'b1000110011}});
        tv[8]  = vv(1, 0, 0, 6'b000000, 8'h01, {3{10'b0111111111}});
        tv[9]  = vv(1, 0, 0, 6'b000000, 8'h01, {3{10'b1100000000}});
        tv[10] = vv(1, 0, 0, 6'b000000, 8'h01, {3{10'b0111111111}});
        tv[11] = vv(0, 0, 1, 6'b010010, 8'h00, {C01, C00, C10});

        rst_n = 1'b0;
        d_de = 0; d_hs = 0; d_vs = 0; d_ctl = '0; d_pix = '0;
        r_de = 0; r_hs = 0; r_vs = 0; r_ctl = '0; r_pix = '0;
        h_de = 0; h_hs = 0; h_vs = 0; h_ctl = '0; h_pix = '0;
        step();
        step();
        check("reset_dvi_tmds", d_tmds, {3{C00}});
        check("reset_rand_tmds", r_tmds, {4{C00}});
        check("reset_hdmi_tmds", h_tmds, {3{C00}});
        check("reset_video", {d_vid, r_vid, h_vid}, 3'b000);
        check("reset_blank_err", {d_err, r_err, h_err}, 3'b000);
        rst_n = 1'b1;

        // Table vectors on the 3-lane DVI instance, latency 2.
        for (int i = 0; i < 14; i++) begin
            step();
            if (i >= 2) begin
                check("table_tmds", d_tmds, tv[i-2].exp);
                check("table_video", d_vid, tv[i-2].de);
            end else begin
                check("post_reset_ctrl", d_tmds, {3{C00}});
            end
            if (i < 12) begin
                d_de = tv[i].de; d_hs = tv[i].hs; d_vs = tv[i].vs;
                d_ctl = tv[i].ctl; d_pix = {3{tv[i].pix}};
            end else begin
                d_de = 0; d_hs = 0; d_vs = 0; d_ctl = '0; d_pix = '0;
            end
        end

        // Reset asserted in the middle of an active line.
        d_de = 1; d_pix = {3{8'h01}};
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        check("midline_reset_tmds", d_tmds, {3{C00}});
        check("midline_reset_video", d_vid, 1'b0);
        step();
        rst_n = 1'b1;
        d_pix = '0;
        step();
        check("after_reset_first", d_tmds, {3{C00}});
        step();
        check("after_reset_video", d_tmds, {3{10'b0100000000}});
        d_de = 0;

        // Random 4-lane run, sync lane 2, against the reference model.
        for (int l = 0; l < 4; l++) begin rc[l] = 0; ds[l] = 0; end
        for (int k = 0; k < RAND_N + 2; k++) begin
            step();
            if (rq.size() == 2) begin
                e = rq.pop_front();
                check("rand_tmds", r_tmds, e.sym);
                check("rand_video", r_vid, e.vid);
                ok = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    if (e.vid) ds[l] += 2 * $countones(r_tmds[10*l +: 10]) - 10;
                    else       ds[l] = 0;
                    if (ds[l] > 10 || ds[l] < -10) ok = 1'b0;
                end
                check("rand_disparity_bound", ok, 1'b1);
            end
            if (k < RAND_N) begin
                r_de  = ($urandom_range(0, 7) != 0);
                r_hs  = $urandom_range(0, 1);
                r_vs  = $urandom_range(0, 1);
                r_ctl = 8'($urandom);
                r_pix = $urandom;
            end else begin
                r_de = 0; r_hs = 0; r_vs = 0; r_ctl = '0; r_pix = '0;
            end
            e.sym = '0;
            e.vid = r_de;
            for (int l = 0; l < 4; l++) begin
                if (r_de) begin
                    ref_video(r_pix[8*l +: 8], rc[l], s, nc);
                    rc[l] = nc;
                end else begin
                    c = (l == 2) ? {r_vs, r_hs} : r_ctl[2*l +: 2];
                    s = ctrl_sym(c);
                    rc[l] = 0;
                end
                e.sym[10*l +: 10] = s;
            end
            rq.push_back(e);
        end

        // HDMI instance: long blank, long blank, then a 5-cycle blank.
        seg_len = '{30, 16, 20, 12, 5, 12, 30};
        idx = 0;
        lvl = 0;
        for (int g = 0; g < 7; g++) begin
            for (int j = 0; j < seg_len[g]; j++) begin
                hde[idx] = lvl[0];
                idx++;
            end
            lvl++;
        end
        for (int t = TOT; t < HLEN; t++) hde[t] = 1'b0;
        r2 = 66;
        pulses = 0;
        for (int l = 0; l < 3; l++) hc[l] = 0;
        for (int t = 0; t < HLEN; t++) begin
            step();
            if (t >= 12) begin
                idx = t - 12;
                cls = hclass(idx);
                for (int l = 0; l < 3; l++) begin
                    case (cls)
                        3: begin
                            ref_video(hpix[idx][8*l +: 8], hc[l], s, nc);
                            hc[l] = nc;
                        end
                        1: begin
                            c = (l == 0) ? {hvs[idx], hhs[idx]} : ((l == 1) ? 2'b01 : 2'b00);
                            s = ctrl_sym(c);
                            hc[l] = 0;
                        end
                        2: begin
                            s = (l == 1) ? G1 : G02;
                            hc[l] = 0;
                        end
                        default: begin
                            c = (l == 0) ? {hvs[idx], hhs[idx]} : hctl[idx][2*l +: 2];
                            s = ctrl_sym(c);
                            hc[l] = 0;
                        end
                    endcase
                    hexp[10*l +: 10] = s;
                end
                check("hdmi_tmds", h_tmds, hexp);
                check("hdmi_video", h_vid, hde[idx]);
            end
            if (t >= 1) begin
                check("hdmi_blank_err", h_err, err_at(t - 1));
                if (h_err) pulses++;
            end
            if (t >= r2 + 2 && t <= r2 + 9)
                check("hdmi_preamble_lanes12", h_tmds[29:10], {C00, C01});
            if (t == r2 + 10 || t == r2 + 11)
                check("hdmi_guard", h_tmds, {G02, G1, G02});
            if (t == r2 + 12)
                check("hdmi_first_video", h_vid, 1'b1);
            hhs[t]  = $urandom_range(0, 1);
            hvs[t]  = $urandom_range(0, 1);
            hctl[t] = 6'($urandom);
            hpix[t] = 24'($urandom);
            h_de = hde[t]; h_hs = hhs[t]; h_vs = hvs[t]; h_ctl = hctl[t]; h_pix = hpix[t];
        end
        check("hdmi_blank_err_pulses", pulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
